// File: rtl/cipher_mem_sequencer_pkg.sv
// rtl/cipher_mem_sequencer_pkg.sv - shared types and constants for the cipher memory sequencer
package cipher_mem_sequencer_pkg;

    localparam int KEY_BYTES = 16;
    localparam int BLK_BYTES = 8;
    localparam int CNT_W     = 5;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_KEY,
        LOAD_PT,
        CORE_GO,
        CORE_WAIT,
        STORE,
        VERIFY,
        DONE
    } state_t;

    function automatic logic [7:0] top_byte(input logic [8*BLK_BYTES-1:0] v);
        return v[8*BLK_BYTES-1 -: 8];
    endfunction

endpackage

// File: rtl/ram_byte_loader.sv
// rtl/ram_byte_loader.sv - reads NBYTES bytes from a 1-cycle-latency RAM, MSB first, into a shift register
module ram_byte_loader #(
    parameter int         NBYTES = 16,
    parameter logic [7:0] BASE   = 8'h00
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  go,
    output logic [7:0]            addr,
    input  logic [7:0]            rdata,
    output logic [8*NBYTES-1:0]   data,
    output logic                  last
);
    import cipher_mem_sequencer_pkg::*;

    localparam cnt_t LAST_ADDR = cnt_t'(NBYTES - 1);
    localparam cnt_t LAST_CNT  = cnt_t'(NBYTES);

    cnt_t cnt;
    logic active;

    // Data for the address issued at count c arrives at count c+1, hence N+1 cycles.
    assign last = active && (cnt == LAST_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            active <= 1'b0;
            cnt    <= '0;
            addr   <= 8'h00;
            data   <= '0;
        end else if (go) begin
            active <= 1'b1;
            cnt    <= '0;
            addr   <= BASE;
        end else if (active) begin
            cnt <= cnt + cnt_t'(1);
            if (cnt < LAST_ADDR)
                addr <= addr + 8'd1;
            if (cnt != '0)
                data <= {data[8*NBYTES-9:0], rdata};
            if (last)
                active <= 1'b0;
        end
    end

endmodule

// File: rtl/cipher_mem_sequencer.sv
// rtl/cipher_mem_sequencer.sv - key/block load, cipher core handshake, result store; SEQ_READBACK_EN adds readback verify
module cipher_mem_sequencer #(
    parameter logic [7:0] KEY_BASE  = 8'h00,
    parameter logic [7:0] PT_BASE   = 8'h00,
    parameter logic [7:0] OUT_BASE  = 8'h00,
    parameter int         KEY_BYTES = cipher_mem_sequencer_pkg::KEY_BYTES,
    parameter int         BLK_BYTES = cipher_mem_sequencer_pkg::BLK_BYTES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic [7:0]             key_addr,
    input  logic [7:0]             key_dout,
    output logic [7:0]             pt_addr,
    input  logic [7:0]             pt_dout,
    output logic                   out_we,
    output logic [7:0]             out_addr,
    output logic [7:0]             out_din,
    input  logic [7:0]             out_dout,
    output logic                   core_start,
    output logic [8*KEY_BYTES-1:0] core_key,
    output logic [8*BLK_BYTES-1:0] core_block,
    input  logic                   core_done,
    input  logic [8*BLK_BYTES-1:0] core_result,
    output logic                   verify_err
);
    import cipher_mem_sequencer_pkg::*;

    localparam cnt_t LAST_BYTE = cnt_t'(BLK_BYTES - 1);

    state_t                 state;
    cnt_t                   cnt;
    logic [8*BLK_BYTES-1:0] result;
    logic [8*BLK_BYTES-1:0] store_sh;
    logic                   key_go, key_last, pt_go, pt_last;

    assign key_go = (state == IDLE) && start;
    assign pt_go  = (state == LOAD_KEY) && key_last;

    ram_byte_loader #(.NBYTES(KEY_BYTES), .BASE(KEY_BASE)) u_key_loader (
        .clk   (clk),
        .rst   (rst),
        .go    (key_go),
        .addr  (key_addr),
        .rdata (key_dout),
        .data  (core_key),
        .last  (key_last)
    );

    ram_byte_loader #(.NBYTES(BLK_BYTES), .BASE(PT_BASE)) u_pt_loader (
        .clk   (clk),
        .rst   (rst),
        .go    (pt_go),
        .addr  (pt_addr),
        .rdata (pt_dout),
        .data  (core_block),
        .last  (pt_last)
    );

    // Byte cnt+1 of the result, lined up at the top for the next STORE beat.
    always_comb begin
        store_sh = result << (8 * (int'(cnt) + 1));
    end

`ifdef SEQ_READBACK_EN
    localparam cnt_t VERIFY_END = cnt_t'(BLK_BYTES);

    logic [8*BLK_BYTES-1:0] verify_sh;

    // out_dout at count c holds the byte written at OUT_BASE+c-1.
    always_comb begin
        verify_sh = result << (8 * int'(cnt - cnt_t'(1)));
    end
`else
    logic unused_out_dout;

    assign unused_out_dout = ^out_dout;
    assign verify_err      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            out_we     <= 1'b0;
            out_addr   <= 8'h00;
            out_din    <= 8'h00;
            core_start <= 1'b0;
            result     <= '0;
            cnt        <= '0;
`ifdef SEQ_READBACK_EN
            verify_err <= 1'b0;
`endif
        end else begin
            done       <= 1'b0;
            core_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD_KEY;
                        busy  <= 1'b1;
`ifdef SEQ_READBACK_EN
                        verify_err <= 1'b0;
`endif
                    end
                end
                LOAD_KEY: begin
                    if (key_last)
                        state <= LOAD_PT;
                end
                LOAD_PT: begin
                    if (pt_last) begin
                        state      <= CORE_GO;
                        core_start <= 1'b1;
                    end
                end
                CORE_GO: begin
                    state <= CORE_WAIT;
                end
                CORE_WAIT: begin
                    if (core_done) begin
                        result   <= core_result;
                        out_we   <= 1'b1;
                        out_addr <= OUT_BASE;
                        out_din  <= top_byte(core_result);
                        cnt      <= '0;
                        state    <= STORE;
                    end
                end
                STORE: begin
                    if (cnt == LAST_BYTE) begin
                        out_we <= 1'b0;
                        cnt    <= '0;
`ifdef SEQ_READBACK_EN
                        out_addr <= OUT_BASE;
                        state    <= VERIFY;
`else
                        done  <= 1'b1;
                        state <= DONE;
`endif
                    end else begin
                        cnt      <= cnt + cnt_t'(1);
                        out_addr <= out_addr + 8'd1;
                        out_din  <= top_byte(store_sh);
                    end
                end
`ifdef SEQ_READBACK_EN
                VERIFY: begin
                    if (cnt != '0 && top_byte(verify_sh) != out_dout)
                        verify_err <= 1'b1;
                    if (cnt == VERIFY_END) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + cnt_t'(1);
                        if (cnt < LAST_BYTE)
                            out_addr <= out_addr + 8'd1;
                    end
                end
`endif
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cipher_mem_sequencer.sv
// tb/tb_cipher_mem_sequencer.sv - scoreboard bench for cipher_mem_sequencer with RAM and core models
module tb_cipher_mem_sequencer;

    localparam int CORE_LAT = 5;
`ifdef SEQ_READBACK_EN
    localparam int LAT_EXP = 50;
`else
    localparam int LAT_EXP = 41;
`endif
    localparam logic [127:0] KEY_A = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] KEY_B = 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF;
    localparam logic [63:0]  BLK   = 64'h1122334455667788;
    localparam logic [63:0]  RES_A = 64'hC3B90EB52256FE61;
    localparam logic [63:0]  RES_B = 64'hEEDDCCBBAA998877;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         busy, done, out_we, core_start, core_done, verify_err;
    logic [7:0]   key_addr, key_dout, pt_addr, pt_dout, out_addr, out_din, out_dout;
    logic [127:0] core_key;
    logic [63:0]  core_block, core_result;

    always #5 clk = ~clk;

    cipher_mem_sequencer #(.KEY_BASE(8'h00), .PT_BASE(8'hFC), .OUT_BASE(8'h00)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .key_addr(key_addr), .key_dout(key_dout), .pt_addr(pt_addr), .pt_dout(pt_dout),
        .out_we(out_we), .out_addr(out_addr), .out_din(out_din), .out_dout(out_dout),
        .core_start(core_start), .core_key(core_key), .core_block(core_block),
        .core_done(core_done), .core_result(core_result), .verify_err(verify_err)
    );

    logic [7:0] key_mem [256];
    logic [7:0] pt_mem  [256];
    logic [7:0] out_mem [256];
    logic       prefill = 1'b0;
    logic       corrupt5 = 1'b0;
    logic       spur_done = 1'b0;

    always @(posedge clk) begin
        key_dout <= key_mem[key_addr];
        pt_dout  <= pt_mem[pt_addr];
        out_dout <= out_mem[out_addr];
        if (prefill) begin
            for (int i = 0; i < 256; i++) out_mem[i] <= 8'hA5;
        end else if (out_we) begin
            out_mem[out_addr] <= (corrupt5 && out_addr == 8'd5) ? (out_din ^ 8'h5A) : out_din;
        end
    end

    // Core model: fixed known-answer vector, otherwise block inverted, CORE_LAT cycles after core_start.
    logic [127:0] key_l;
    logic [63:0]  blk_l;
    int           ccnt = 0;
    always @(posedge clk) begin
        core_done <= 1'b0;
        if (spur_done) begin
            core_done   <= 1'b1;
            core_result <= 64'hDEAD_BEEF_0BAD_F00D;
        end else if (core_start) begin
            ccnt  <= 1;
            key_l <= core_key;
            blk_l <= core_block;
        end else if (ccnt != 0) begin
            if (ccnt == CORE_LAT - 1) begin
                core_done   <= 1'b1;
                core_result <= (key_l == KEY_A && blk_l == BLK) ? RES_A : ~blk_l;
                ccnt        <= 0;
            end else begin
                ccnt <= ccnt + 1;
            end
        end
    end

    int tests = 0;
    int fails = 0;

    logic [127:0] exp_key [$];
    logic [63:0]  exp_blk [$];
    logic [7:0]   exp_pta [$];
    logic [15:0]  exp_wr  [$];
    int           exp_lat [$];
    logic         exp_verr [$];

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic unexpected(input string name);
        tests++;
        fails++;
        $display("FAIL %s: event seen, none expected", name);
    endtask

    task automatic push_op(input logic [127:0] k, input logic [63:0] r, input int nwr,
                           input bit with_done, input logic verr);
        exp_key.push_back(k);
        exp_blk.push_back(BLK);
        for (int i = 0; i < 8; i++) exp_pta.push_back(8'hFC + 8'(i));
        for (int i = 0; i < nwr; i++) exp_wr.push_back({8'(i), r[8*(7-i) +: 8]});
        if (with_done) begin
            exp_lat.push_back(LAT_EXP);
            exp_verr.push_back(verr);
        end
    endtask

    // Monitor: cyc = 1 in the first busy cycle after start is accepted.
    int   cyc = 0;
    logic busy_q = 1'b0;
    always @(negedge clk) begin
        if (busy === 1'b1 && busy_q !== 1'b1) cyc = 1;
        else if (busy === 1'b1) cyc = cyc + 1;
        if (busy === 1'b1 && cyc >= 18 && cyc <= 25) begin
            if (exp_pta.size() == 0) unexpected("pt_addr");
            else check("pt_addr", 128'(pt_addr), 128'(exp_pta.pop_front()));
        end
        if (core_start === 1'b1) begin
            if (exp_key.size() == 0) unexpected("core_start");
            else begin
                check("core_key", core_key, exp_key.pop_front());
                check("core_block", 128'(core_block), 128'(exp_blk.pop_front()));
            end
        end
        if (out_we === 1'b1) begin
            if (exp_wr.size() == 0) unexpected("out_write");
            else check("out_write addr_data", 128'({out_addr, out_din}), 128'(exp_wr.pop_front()));
        end
        if (done === 1'b1) begin
            if (exp_lat.size() == 0) unexpected("done");
            else begin
                check("done_latency", 128'(cyc), 128'(exp_lat.pop_front()));
                check("verify_err_at_done", 128'(verify_err), 128'(exp_verr.pop_front()));
            end
        end
        busy_q = busy;
    end

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL wait_done: got no done within %0d cycles, required a done pulse", budget);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic set_key(input logic [7:0] first);
        for (int i = 0; i < 16; i++) key_mem[i] = first + 8'(i);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            key_mem[i] = 8'h00;
            pt_mem[i]  = 8'h00;
        end
        set_key(8'h00);
        for (int i = 0; i < 8; i++) pt_mem[8'hFC + 8'(i)] = 8'(17 * (i + 1));

        prefill = 1'b1;
        repeat (3) @(negedge clk);
        prefill = 1'b0;
        check("rst busy", 128'(busy), 128'(0));
        check("rst done", 128'(done), 128'(0));
        check("rst out_we", 128'(out_we), 128'(0));
        check("rst core_start", 128'(core_start), 128'(0));
        check("rst verify_err", 128'(verify_err), 128'(0));
        check("rst addrs", 128'({key_addr, pt_addr, out_addr}), 128'(0));
        check("rst out_din", 128'(out_din), 128'(0));
        check("rst core_key", core_key, 128'(0));
        check("rst core_block", 128'(core_block), 128'(0));
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Known-answer vector.
        push_op(KEY_A, RES_A, 8, 1'b1, 1'b0);
        do_start();
        wait_done(200);
        check("out_mem[0]", 128'(out_mem[0]), 128'(8'hC3));
        check("out_mem[7]", 128'(out_mem[7]), 128'(8'h61));

        // Inverting core, fixed latency.
        set_key(8'hF0);
        push_op(KEY_B, RES_B, 8, 1'b1, 1'b0);
        do_start();
        wait_done(200);
        check("out_mem[3]", 128'(out_mem[3]), 128'(8'hBB));

        // Stray start pulses and a stray core_done must not disturb the operation.
        push_op(KEY_B, RES_B, 8, 1'b1, 1'b0);
        do_start();
        repeat (19) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        repeat (LAT_EXP - 36) @(negedge clk);
        check("done_in_cycle", 128'(done), 128'(1));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("start_in_done_ignored busy", 128'(busy), 128'(0));
        repeat (2) @(negedge clk);

        // Reset while byte 3 is being written.
        prefill = 1'b1;
        @(negedge clk);
        prefill = 1'b0;
        push_op(KEY_B, RES_B, 4, 1'b0, 1'b0);
        do_start();
        begin
            bit hit = 1'b0;
            for (int i = 0; i < 200 && !hit; i++) begin
                if (out_we === 1'b1 && out_addr == 8'd3) hit = 1'b1;
                else @(negedge clk);
            end
            tests++;
            if (!hit) begin
                fails++;
                $display("FAIL store_byte3_wait: got no write to addr 3, required one");
            end
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid out_we", 128'(out_we), 128'(0));
        check("rst_mid busy", 128'(busy), 128'(0));
        repeat (2) @(negedge clk);
        check("rst_mid out_mem[3]", 128'(out_mem[3]), 128'(8'hBB));
        check("rst_mid out_mem[4]", 128'(out_mem[4]), 128'(8'hA5));

        // Fresh operation after the abort.
        push_op(KEY_B, RES_B, 8, 1'b1, 1'b0);
        do_start();
        wait_done(200);
        check("after_rst out_mem[4]", 128'(out_mem[4]), 128'(8'hAA));

`ifdef SEQ_READBACK_EN
        corrupt5 = 1'b1;
        push_op(KEY_B, RES_B, 8, 1'b1, 1'b1);
        do_start();
        wait_done(200);
        corrupt5 = 1'b0;
        check("verify_err sticky", 128'(verify_err), 128'(1));
        push_op(KEY_B, RES_B, 8, 1'b1, 1'b0);
        do_start();
        check("verify_err cleared on start", 128'(verify_err), 128'(0));
        wait_done(200);
`endif

        check("scoreboard drained", 128'(exp_wr.size() + exp_lat.size() + exp_pta.size() + exp_key.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
